// File: rtl/remainder_calculator.sv
// remainder_calculator: pipelined unsigned modulo, one restoring-division step per stage
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset, clears every stage and the output
//   dividend  - WIDTH-bit unsigned dividend, sampled every cycle
//   divisor   - WIDTH-bit unsigned divisor, sampled every cycle (0 yields the dividend)
//   remainder - registered dividend mod divisor, WIDTH cycles after sampling
module remainder_calculator #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] p  [WIDTH];
    logic [WIDTH-1:0] pn [WIDTH];
    logic [WIDTH-1:0] n  [WIDTH-1];
    logic [WIDTH-1:0] nn [WIDTH-1];
    logic [WIDTH-1:0] d  [WIDTH-1];
    logic [WIDTH-1:0] dn [WIDTH-1];

    for (genvar g = 0; g < WIDTH; g++) begin : stage
        logic [WIDTH-1:0] pi;
        logic [WIDTH-1:0] di;
        logic             b;
        logic [WIDTH:0]   t;
        if (g == 0) begin : first
            assign pi    = '0;
            assign di    = divisor;
            assign b     = dividend[WIDTH-1];
            assign nn[0] = {dividend[WIDTH-2:0], 1'b0};
        end else begin : rest
            assign pi = p[g-1];
            assign di = d[g-1];
            assign b  = n[g-1][WIDTH-1];
            if (g < WIDTH-1) begin : fwd
                assign nn[g] = {n[g-1][WIDTH-2:0], 1'b0};
            end
        end
        if (g < WIDTH-1) begin : keep
            assign dn[g] = di;
        end
        // Shifted partial remainder held in WIDTH+1 bits; after a subtract it
        // always fits back in WIDTH bits, so the low-bit difference is exact.
        assign t     = {pi, b};
        assign pn[g] = (t >= {1'b0, di}) ? t[WIDTH-1:0] - di : t[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) p[i] <= '0;
            for (int i = 0; i < WIDTH-1; i++) begin
                n[i] <= '0;
                d[i] <= '0;
            end
        end else begin
            p <= pn;
            n <= nn;
            d <= dn;
        end
    end

    assign remainder = p[WIDTH-1];
endmodule

// File: tb/tb_remainder_calculator.sv
// tb_remainder_calculator: scoreboard bench for the pipelined modulo unit
module tb_remainder_calculator;
    localparam int W   = 20;
    localparam int LAT = W;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] remainder;

    typedef struct {
        int           due;
        logic [W-1:0] v;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    remainder_calculator #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .dividend(dividend),
        .divisor(divisor),
        .remainder(remainder)
    );

    // Drive one operand pair, record what must emerge, then check every
    // expectation falling due on this edge.
    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b, input int id);
        exp_t e;
        rst      = r;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        cyc++;
        if (r) begin
            sb.delete();
            for (int i = 0; i < LAT; i++) sb.push_back('{cyc + i, '0, id});
        end else begin
            sb.push_back('{cyc + LAT - 1, (b == 0) ? a : a % b, id});
        end
        #1;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            assert (remainder === e.v) else begin
                fails++;
                $error("FAIL phase%0d cycle %0d: remainder=%0d expected=%0d", e.id, cyc, remainder, e.v);
            end
        end
    endtask

    initial begin
        step(1'b1, W'($urandom), W'($urandom), 0);
        step(1'b1, W'($urandom), W'($urandom), 0);
        for (int i = 0; i < W + 2; i++) step(1'b0, '0, '0, 1);
        step(1'b0, 50, 7, 2);
        step(1'b0, 100, 13, 2);
        step(1'b0, 10, 2, 2);
        step(1'b0, 20, 20, 2);
        step(1'b0, 1048575, 1, 3);
        step(1'b0, 1048575, 1048575, 3);
        step(1'b0, 1048575, 2, 3);
        step(1'b0, 3, 10, 3);
        step(1'b0, 0, 5, 3);
        step(1'b0, 5, 0, 4);
        step(1'b0, 1048575, 0, 4);
        for (int i = 1; i <= 8; i++) step(i == 4, W'(1000 + i * 37), W'(3 + i), 5);
        for (int i = 0; i < 10000; i++)
            step(1'b0, W'($urandom), W'($urandom_range(1, (1 << W) - 1)), 6);
        for (int i = 0; i < LAT; i++) step(1'b0, '0, '0, 7);
        checks++;
        assert (sb.size() == LAT - 1) else begin
            fails++;
            $error("FAIL drain: pending=%0d expected=%0d", sb.size(), LAT - 1);
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
